alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequences the shared ALU datapath in the calculator top level.
- Accepts operation commands over a valid/ready handshake and drives operands and func to the ALU, holding them stable for a fixed settle latency.
- Captures result and overflow, then presents them on a valid/ready response port to the display/BCD path.
- Optional auto-cycle mode steps through all four ALU functions on the last operands for demo display.

Parameters:
WIDTH, 6, operand width; ALU result is 2*WIDTH
ALU_LAT, 2, cycles operands are held before the ALU result is sampled; legal range >= 1
DWELL, 50000000, idle cycles between auto-cycle steps; legal range >= 2
DWELL_W, 26, dwell counter width; must satisfy 2^DWELL_W > DWELL

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_a  in  WIDTH  operand a (two's complement)
cmd_b  in  WIDTH  operand b
cmd_func  in  3  [1:0] ALU op; [2] show-operands mode
auto_en  in  1  enable auto-cycle mode
alu_a  out  WIDTH  ALU operand a, registered
alu_b  out  WIDTH  ALU operand b, registered
alu_func  out  2  ALU op select, registered
alu_out  in  2*WIDTH  ALU result
alu_ovf  in  1  ALU overflow/error
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  2*WIDTH  result, or {a,b} in show-operands mode
rsp_err  out  1  captured overflow
rsp_func  out  3  func of this response
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE.
  - alu_a, alu_b, alu_func, rsp_data, rsp_err, rsp_func, rsp_valid, and the dwell counter are all cleared to 0.
  - cmd_ready = 0 while rst_n is low.
  - Reset mid-operation aborts immediately; a pending response is lost.
- cmd_ready = (state == IDLE) && rst_n. This is combinational from state only and never depends on cmd_valid.
- States: IDLE, ISSUE, DONE.
  - IDLE -> ISSUE on an accepted command (external or auto).
  - ISSUE -> DONE after ALU_LAT cycles.
  - DONE -> IDLE on rsp_valid && rsp_ready.
- Accept (edge with cmd_valid && cmd_ready):
  - alu_a/alu_b/alu_func <= cmd_a/cmd_b/cmd_func[1:0].
  - The internal func register <= cmd_func.
  - Latency counter <= ALU_LAT-1.
- ISSUE:
  - ALU inputs are held stable; the counter decrements each edge.
  - On the edge where the counter is 0: capture and go to DONE.
  - Capture: rsp_data <= alu_out, rsp_err <= alu_ovf, rsp_func <= func, rsp_valid <= 1.
  - rsp_valid is first seen high after the ALU_LAT-th edge following the accept edge.
- Show-operands (func[2] = 1):
  - The ALU is still driven.
  - rsp_data <= {alu_a, alu_b} and rsp_err <= 0.
- DONE:
  - rsp_* are held stable while rsp_valid is high and rsp_ready is low.
  - On the handshake edge: rsp_valid <= 0, state IDLE.
  - cmd_ready rises the cycle after.
  - Peak throughput: one command per ALU_LAT+2 cycles.
- alu_a/alu_b/alu_func keep their last values outside ISSUE; they change only on an accept.
- Auto-cycle:
  - In IDLE with auto_en = 1 and cmd_valid = 0, the dwell counter increments every cycle.
  - On the edge where the counter equals DWELL-1, an internal command is accepted:
    - operands unchanged;
    - alu_func <= alu_func + 1, wrapping 11 -> 00;
    - func[2] = 0;
    - counter cleared.
  - The counter clears when auto_en = 0, on any external accept, and outside IDLE.
  - Simultaneous cmd_valid and terminal count: the external command wins and the counter clears.
- busy = (state != IDLE). Reset value is 0.
- Operands and results are treated as opaque bit vectors; no sign handling is done inside the block.

Test Plan:
- Bench settings: WIDTH=6, ALU_LAT=2, DWELL=8. Behavioural ALU model with 1-cycle registered output: 00 add, 01 sub, 10 mul, 11 div, all signed. Model ovf is set on div-by-zero.
- Basic mul: reset 3 cycles, then cmd a=5, b=3, func=010 accepted at edge 0.
  -> rsp_valid rises after edge 2; rsp_data=15, rsp_err=0, rsp_func=010; cmd_ready=0 and busy=1 until the response handshake.
- Backpressure: a=-7 (6'b111001), b=2, func=000, rsp_ready held low 5 cycles.
  -> rsp_data=0xFFB (-5) stable throughout the stall; cmd_ready stays 0; on the rsp_ready edge rsp_valid drops and cmd_ready=1 the next cycle.
- Show-operands and div-by-zero:
  - cmd a=12, b=0, func=111 -> rsp_data={6'd12, 6'd0}=0x300, rsp_err=0.
  - then func=011 -> rsp_err=1.
- Auto-cycle: after cmd a=6, b=2, func=000 completes, hold auto_en=1 and rsp_ready=1.
  -> responses every 8+ALU_LAT+2 cycles with rsp_func 001, 010, 011, 000 and data 4, 12, 3, 8.
  -> cmd_valid asserted on the terminal-count cycle is accepted instead of the auto step.
- Reset mid-op: rst_n low during ISSUE.
  -> after one edge rsp_valid=0, busy=0, alu_func=00, alu_a=0; no response is emitted after reset release.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequencer for the shared calculator ALU: accepts commands, holds operands for ALU_LAT cycles,
// captures the result and offers it on a valid/ready response port; optional auto-cycle demo.
module alu_op_sequencer #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned DWELL   = 50000000,
  parameter int unsigned DWELL_W = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [2:0]         cmd_func,
  input  logic               auto_en,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_func,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_ovf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_err,
  output logic [2:0]         rsp_func,
  output logic               busy
);

  localparam int unsigned LatW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e               state_q, state_d;
  logic [LatW-1:0]      lat_q, lat_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [2:0]           func_q, func_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]           alu_func_q, alu_func_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [2:0]           rsp_func_q, rsp_func_d;

  assign cmd_ready = (state_q == StIdle) && rst_n;
  assign busy      = (state_q != StIdle);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_func  = alu_func_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_func  = rsp_func_q;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    dwell_d     = '0;
    func_d      = func_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_func_d  = rsp_func_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d    = cmd_a;
          alu_b_d    = cmd_b;
          alu_func_d = cmd_func[1:0];
          func_d     = cmd_func;
          lat_d      = LatW'(ALU_LAT - 1);
          state_d    = StIssue;
        end else if (auto_en && !cmd_valid) begin
          // Terminal count replays the last operands with the next ALU function.
          if (dwell_q == DWELL_W'(DWELL - 1)) begin
            alu_func_d = alu_func_q + 2'd1;
            func_d     = {1'b0, alu_func_q + 2'd1};
            lat_d      = LatW'(ALU_LAT - 1);
            state_d    = StIssue;
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
      end
      StIssue: begin
        if (lat_q == '0) begin
          if (func_q[2]) begin
            rsp_data_d = {alu_a_q, alu_b_q};
            rsp_err_d  = 1'b0;
          end else begin
            rsp_data_d = alu_out;
            rsp_err_d  = alu_ovf;
          end
          rsp_func_d  = func_q;
          rsp_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          lat_d = lat_q - LatW'(1);
        end
      end
      StDone: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      dwell_q     <= '0;
      func_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_func_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      dwell_q     <= dwell_d;
      func_q      <= func_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_func_q  <= rsp_func_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural signed ALU plus a response model computed from the
// command (directed cases, auto-cycle, reset abort and randomized commands).
module tb_alu_op_sequencer;

  localparam int unsigned WIDTH   = 6;
  localparam int unsigned ALU_LAT = 2;
  localparam int unsigned DWELL   = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [WIDTH-1:0]   cmd_a, cmd_b;
  logic [2:0]         cmd_func;
  logic               auto_en;
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [1:0]         alu_func;
  logic [2*WIDTH-1:0] alu_out;
  logic               alu_ovf;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*WIDTH-1:0] rsp_data;
  logic               rsp_err;
  logic [2:0]         rsp_func;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(
    .WIDTH  (WIDTH),
    .ALU_LAT(ALU_LAT),
    .DWELL  (DWELL),
    .DWELL_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_func (cmd_func),
    .auto_en  (auto_en),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_func (alu_func),
    .alu_out  (alu_out),
    .alu_ovf  (alu_ovf),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .rsp_func (rsp_func),
    .busy     (busy)
  );

  // Signed ALU: returns {ovf, result}; divide by zero flags ovf with result 0.
  function automatic logic [12:0] alu_ref(input logic [5:0] a, input logic [5:0] b,
                                          input logic [1:0] f);
    logic signed [11:0] ea, eb, r;
    logic ovf;
    ea  = {{6{a[5]}}, a};
    eb  = {{6{b[5]}}, b};
    ovf = 1'b0;
    case (f)
      2'd0: r = ea + eb;
      2'd1: r = ea - eb;
      2'd2: r = ea * eb;
      default: begin
        if (eb == 0) begin
          r   = '0;
          ovf = 1'b1;
        end else begin
          r = ea / eb;
        end
      end
    endcase
    return {ovf, r};
  endfunction

  // Expected response {err, data} for a command.
  function automatic logic [12:0] rsp_ref(input logic [5:0] a, input logic [5:0] b,
                                          input logic [2:0] f);
    if (f[2]) return {1'b0, a, b};
    return alu_ref(a, b, f[1:0]);
  endfunction

  logic [12:0] alu_res;
  always @(posedge clk) begin
    alu_res = alu_ref(alu_a, alu_b, alu_func);
    alu_out <= alu_res[11:0];
    alu_ovf <= alu_res[12];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_func  = f;
    step();
    cmd_valid = 1'b0;
    check("accept_alu_a", alu_a, a);
    check("accept_alu_b", alu_b, b);
    check("accept_alu_func", alu_func, f[1:0]);
    check("accept_busy", busy, 1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      step();
      lat++;
    end
    check("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic consume(input logic [12:0] exp, input logic [2:0] f, input int stall);
    check("rsp_data", rsp_data, exp[11:0]);
    check("rsp_err", rsp_err, exp[12]);
    check("rsp_func", rsp_func, f);
    check("done_cmd_ready", cmd_ready, 0);
    check("done_busy", busy, 1);
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, exp[11:0]);
      check("stall_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("hs_valid_drop", rsp_valid, 0);
    check("hs_cmd_ready", cmd_ready, 1);
    check("hs_busy", busy, 0);
  endtask

  task automatic run_cmd(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f,
                         input int stall);
    int lat;
    send(a, b, f);
    check("post_accept_valid", rsp_valid, 0);
    wait_rsp(lat);
    check("latency", lat, ALU_LAT);
    consume(rsp_ref(a, b, f), f, stall);
  endtask

  initial begin
    int          lat, last_t, seen;
    logic [1:0]  last_f, nf;
    logic [12:0] exp;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_func  = '0;
    auto_en   = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_func", alu_func, 0);
    check("rst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    step();
    check("idle_cmd_ready", cmd_ready, 1);

    // Basic multiply
    send(6'd5, 6'd3, 3'b010);
    check("mul_valid_e0", rsp_valid, 0);
    step();
    check("mul_valid_e1", rsp_valid, 0);
    check("mul_cmd_ready_e1", cmd_ready, 0);
    step();
    check("mul_valid_e2", rsp_valid, 1);
    check("mul_data_const", rsp_data, 12'd15);
    consume(rsp_ref(6'd5, 6'd3, 3'b010), 3'b010, 0);

    // Backpressure on -7 + 2
    send(6'b111001, 6'd2, 3'b000);
    wait_rsp(lat);
    check("bp_data_const", rsp_data, 12'hFFB);
    consume(rsp_ref(6'b111001, 6'd2, 3'b000), 3'b000, 5);

    // Show operands, then divide by zero
    send(6'd12, 6'd0, 3'b111);
    wait_rsp(lat);
    check("show_data_const", rsp_data, 12'h300);
    consume(rsp_ref(6'd12, 6'd0, 3'b111), 3'b111, 1);
    send(6'd12, 6'd0, 3'b011);
    wait_rsp(lat);
    check("div0_err_const", rsp_err, 1);
    consume(rsp_ref(6'd12, 6'd0, 3'b011), 3'b011, 0);

    // Auto-cycle
    run_cmd(6'd6, 6'd2, 3'b000, 0);
    rsp_ready = 1'b1;
    auto_en   = 1'b1;
    last_f    = 2'd0;
    last_t    = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(lat);
      nf  = last_f + 2'd1;
      exp = rsp_ref(6'd6, 6'd2, {1'b0, nf});
      check("auto_func", rsp_func, {1'b0, nf});
      check("auto_data", rsp_data, exp[11:0]);
      check("auto_err", rsp_err, exp[12]);
      if (i > 0)
        check("auto_gap", (cyc - last_t >= DWELL) && (cyc - last_t <= DWELL + ALU_LAT + 2), 1);
      last_t = cyc;
      last_f = nf;
      step();
    end
    // External command on the terminal-count cycle beats the auto step
    repeat (DWELL - 1) step();
    cmd_valid = 1'b1;
    cmd_a     = 6'd10;
    cmd_b     = 6'd3;
    cmd_func  = 3'b010;
    step();
    cmd_valid = 1'b0;
    check("ovr_alu_func", alu_func, 2'd2);
    check("ovr_alu_a", alu_a, 6'd10);
    wait_rsp(lat);
    check("ovr_data", rsp_data, 12'd30);
    check("ovr_func", rsp_func, 3'b010);
    step();
    auto_en   = 1'b0;
    rsp_ready = 1'b0;
    step();

    // Reset during ISSUE
    send(6'd7, 6'd9, 3'b001);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_alu_func", alu_func, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    check("mid_rst_no_rsp", seen, 0);

    // Randomized commands
    for (int i = 0; i < 30; i++) begin
      run_cmd(6'($urandom), 6'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
